// File: rtl/bypass_fifo_pkg.sv
// Shared defaults and status record for the bypass stream FIFO.
// Status count is kept wide enough for any supported DEPTH (up to 255 entries).
package bypass_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int STAT_CW   = 8;

  typedef struct packed {
    logic [STAT_CW-1:0] count;
    logic               full;
    logic               empty;
    logic               ovf_err;
  } fifo_status_t;

  // Advance a count by +1, -1 or not at all depending on push/pop.
  function automatic logic [STAT_CW-1:0] count_step(input logic [STAT_CW-1:0] cnt,
                                                     input logic push,
                                                     input logic pop);
    logic [STAT_CW-1:0] res;
    res = cnt;
    if (push && !pop) begin
      res = cnt + STAT_CW'(1);
    end else if (pop && !push) begin
      res = cnt - STAT_CW'(1);
    end else begin
      res = cnt;
    end
    return res;
  endfunction

endpackage

// File: rtl/bypass_fifo_ptr.sv
// Wrapping FIFO index: PW-bit counter with enable and synchronous clear,
// returning to 0 after DEPTH-1.
module bypass_fifo_ptr #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_r;

  // Pointer register: clear, wrap at the last slot, or increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (en) begin
      if (ptr_r == PW'(DEPTH - 1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= ptr_r + PW'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/bypass_stream_fifo.sv
// Stream FIFO with zero-latency bypass when empty, a registered status
// record, and an oldest-first window view including the incoming word.
module bypass_stream_fifo
  import bypass_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_ready,
  output logic                   rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  input  logic                   rd_ready,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   empty,
  output logic [WIDTH*DEPTH-1:0] window,
  output logic [DEPTH-1:0]       window_valid,
  output logic                   ovf_err
);

  fifo_status_t       status_r;
  logic [WIDTH-1:0]   buf_r [DEPTH];
  logic [PW-1:0]      rd_ptr_s;
  logic [PW-1:0]      wr_ptr_s;
  logic               wr_fire_s;
  logic               rd_fire_s;
  logic               bypass_s;
  logic               store_s;
  logic               pop_s;
  logic [STAT_CW-1:0] cnt_nxt_s;
  logic [WIDTH*DEPTH-1:0] window_s;
  logic [DEPTH-1:0]   window_valid_s;

  assign wr_ready  = ~status_r.full;
  assign rd_valid  = ~status_r.empty | wr_valid;
  assign rd_data   = status_r.empty ? wr_data : buf_r[rd_ptr_s];
  assign wr_fire_s = wr_valid & wr_ready;
  assign rd_fire_s = rd_valid & rd_ready;

  // An empty FIFO hands a simultaneous write straight to the reader.
  assign bypass_s  = status_r.empty & wr_fire_s & rd_fire_s;
  assign store_s   = wr_fire_s & ~bypass_s;
  assign pop_s     = rd_fire_s & ~status_r.empty;
  assign cnt_nxt_s = count_step(status_r.count, store_s, pop_s);

  bypass_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .en  (pop_s),
    .ptr (rd_ptr_s)
  );

  bypass_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (store_s),
    .ptr (wr_ptr_s)
  );

  // Status record: count, full/empty decode and overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_r.count   <= '0;
      status_r.full    <= 1'b0;
      status_r.empty   <= 1'b1;
      status_r.ovf_err <= 1'b0;
    end else begin
      status_r.count   <= cnt_nxt_s;
      status_r.full    <= (cnt_nxt_s == STAT_CW'(DEPTH));
      status_r.empty   <= (cnt_nxt_s == STAT_CW'(0));
      status_r.ovf_err <= wr_valid & status_r.full;
    end
  end

  // Storage array: cleared on reset, written only on a non-bypassed write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_r[i] <= '0;
      end
    end else if (store_s) begin
      buf_r[wr_ptr_s] <= wr_data;
    end else begin
      buf_r <= buf_r;
    end
  end

  // Window: stored entries oldest-first, then the incoming word at slot count.
  always_comb begin
    window_s       = '0;
    window_valid_s = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (STAT_CW'(j) < status_r.count) begin
        window_s[j*WIDTH +: WIDTH] = buf_r[rd_ptr_s + PW'(j)];
        window_valid_s[j]          = 1'b1;
      end else if ((STAT_CW'(j) == status_r.count) && wr_valid) begin
        window_s[j*WIDTH +: WIDTH] = wr_data;
        window_valid_s[j]          = 1'b1;
      end else begin
        window_s[j*WIDTH +: WIDTH] = '0;
        window_valid_s[j]          = 1'b0;
      end
    end
  end

  assign count        = status_r.count[CW-1:0];
  assign full         = status_r.full;
  assign empty        = status_r.empty;
  assign ovf_err      = status_r.ovf_err;
  assign window       = window_s;
  assign window_valid = window_valid_s;

endmodule

// File: tb/tb_bypass_stream_fifo.sv
// Directed bench for bypass_stream_fifo (WIDTH=8, DEPTH=4): bypass, fill/drain,
// overflow, wrap under simultaneous traffic, look-ahead and mid-run reset.
module tb_bypass_stream_fifo;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic [31:0] window;
  logic [3:0]  window_valid;
  logic        ovf_err;

  int n_cmp;
  int n_err;

  bypass_stream_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .window       (window),
    .window_valid (window_valid),
    .ovf_err      (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    rd_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_ovf", 64'(ovf_err), 64'd0);
    chk("rst_wvalid", 64'(window_valid), 64'h0);

    // Bypass
    wr_valid = 1'b1; wr_data = 8'hA5; rd_ready = 1'b1;
    #1;
    chk("byp_rd_valid", 64'(rd_valid), 64'd1);
    chk("byp_rd_data", 64'(rd_data), 64'hA5);
    chk("byp_wvalid", 64'(window_valid), 64'h1);
    tick();
    chk("byp_count", 64'(count), 64'd0);
    chk("byp_empty", 64'(empty), 64'd1);

    // Fill
    rd_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wr_data = 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    #1;
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_window", 64'(window), 64'h04030201);
    chk("fill_wvalid", 64'(window_valid), 64'hF);
    chk("fill_wr_ready", 64'(wr_ready), 64'd0);

    // Overflow
    wr_valid = 1'b1; wr_data = 8'h99;
    #1;
    chk("ovf_wr_ready", 64'(wr_ready), 64'd0);
    chk("ovf_pre", 64'(ovf_err), 64'd0);
    tick();
    wr_valid = 1'b0;
    #1;
    chk("ovf_pulse", 64'(ovf_err), 64'd1);
    chk("ovf_count", 64'(count), 64'd4);
    chk("ovf_window", 64'(window), 64'h04030201);
    tick();
    chk("ovf_clear", 64'(ovf_err), 64'd0);

    // Drain
    rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("drain_valid", 64'(rd_valid), 64'd1);
      chk("drain_data", 64'(rd_data), 64'(i));
      tick();
    end
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_rd_valid", 64'(rd_valid), 64'd0);

    // Empty with rd_ready high and no write: nothing happens
    tick();
    chk("idle_count", 64'(count), 64'd0);
    chk("idle_empty", 64'(empty), 64'd1);

    // Wrap with simultaneous traffic at count=2
    rd_ready = 1'b0; wr_valid = 1'b1;
    wr_data = 8'h20; tick();
    wr_data = 8'h21; tick();
    chk("wrap_pre_count", 64'(count), 64'd2);
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'h22 + 8'(i);
      #1;
      chk("wrap_data", 64'(rd_data), 64'(8'h20 + 8'(i)));
      tick();
      chk("wrap_count", 64'(count), 64'd2);
    end
    wr_valid = 1'b0;
    #1;
    chk("wrap_tail0", 64'(rd_data), 64'h2A);
    tick();
    chk("wrap_tail1", 64'(rd_data), 64'h2B);
    tick();
    chk("wrap_empty", 64'(empty), 64'd1);

    // Look-ahead
    rd_ready = 1'b0; wr_valid = 1'b1; wr_data = 8'h11;
    tick();
    wr_data = 8'h22;
    #1;
    chk("la_count", 64'(count), 64'd1);
    chk("la_window", 64'(window[15:0]), 64'h2211);
    chk("la_wvalid", 64'(window_valid), 64'h3);
    chk("la_rd_data", 64'(rd_data), 64'h11);
    tick();
    wr_data = 8'h33;
    tick();
    wr_valid = 1'b0;
    #1;
    chk("mid_count", 64'(count), 64'd3);
    chk("mid_window", 64'(window), 64'h00332211);

    // Reset mid-operation with a write offered
    rst = 1'b1; wr_valid = 1'b1; wr_data = 8'h44;
    #1;
    chk("rstmid_bypass", 64'(rd_valid), 64'd1);
    tick();
    rst = 1'b0; wr_valid = 1'b0;
    #1;
    chk("rstmid_count", 64'(count), 64'd0);
    chk("rstmid_empty", 64'(empty), 64'd1);
    chk("rstmid_wvalid", 64'(window_valid), 64'h0);
    chk("rstmid_window", 64'(window), 64'h0);
    chk("rstmid_rd_valid", 64'(rd_valid), 64'd0);
    tick();
    chk("rstmid_hold", 64'(count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
